// File: rtl/pb_rst_boot_seq.sv
// rtl/pb_rst_boot_seq.sv - reset and boot-strap sequencer; optional RTC watchdog under PB_RST_BOOT_SEQ_WDT_EN
module pb_rst_boot_seq #(
    parameter int HoldCycles        = 16,
    parameter int PeriphToSocCycles = 8,
    parameter int WdtTicks          = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] boot_mode_i,
    input  logic       test_mode_i,
    input  logic       rtc_i,
    input  logic       sw_rst_req_i,
    input  logic       wdt_kick_i,
    output logic       periph_rst_no,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       test_mode_o,
    output logic [1:0] state_o,
    output logic [1:0] rst_cause_o,
    output logic       wdt_expired_o
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_PERIPH = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    localparam int CntMax = (HoldCycles > PeriphToSocCycles) ? HoldCycles : PeriphToSocCycles;
    localparam int CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] PeriphLast = CntW'(PeriphToSocCycles - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            periph_q, periph_d;
    logic            soc_q, soc_d;
    logic [1:0]      boot_q, boot_d;
    logic            test_q, test_d;
    logic [1:0]      cause_q, cause_d;
    logic            wdt_exp_q, wdt_exp_d;
    logic            wdt_hit;

`ifdef PB_RST_BOOT_SEQ_WDT_EN
    localparam int WdtW = $clog2(WdtTicks + 1);

    logic            rtc_s1_q, rtc_s2_q, rtc_prev_q;
    logic            rtc_tick;
    logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rtc_s1_q   <= 1'b0;
            rtc_s2_q   <= 1'b0;
            rtc_prev_q <= 1'b0;
            wdt_cnt_q  <= '0;
        end else begin
            rtc_s1_q   <= rtc_i;
            rtc_s2_q   <= rtc_s1_q;
            rtc_prev_q <= rtc_s2_q;
            wdt_cnt_q  <= wdt_cnt_d;
        end
    end

    assign rtc_tick = rtc_s2_q & ~rtc_prev_q;
    assign wdt_hit  = (state_q == ST_RUN) && (wdt_cnt_q == WdtW'(WdtTicks));

    // Counting only in RUN; a kick beats a coincident tick.
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if ((state_q != ST_RUN) || wdt_hit || wdt_kick_i) begin
            wdt_cnt_d = '0;
        end else if (rtc_tick) begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end
`else
    logic unused_wdt_inputs;
    assign unused_wdt_inputs = rtc_i ^ wdt_kick_i;
    assign wdt_hit           = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        periph_d  = periph_q;
        soc_d     = soc_q;
        boot_d    = boot_q;
        test_d    = test_q;
        cause_d   = cause_q;
        wdt_exp_d = 1'b0;
        case (state_q)
            ST_HOLD: begin
                periph_d = 1'b0;
                soc_d    = 1'b0;
                if (cnt_q == HoldLast) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                boot_d   = boot_mode_i;
                test_d   = test_mode_i;
                periph_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_PERIPH;
            end
            ST_PERIPH: begin
                if (cnt_q == PeriphLast) begin
                    state_d = ST_RUN;
                    soc_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // Watchdog expiry outranks a simultaneous software request.
                if (wdt_hit || sw_rst_req_i) begin
                    state_d   = ST_HOLD;
                    periph_d  = 1'b0;
                    soc_d     = 1'b0;
                    cnt_d     = '0;
                    cause_d   = wdt_hit ? 2'd2 : 2'd1;
                    wdt_exp_d = wdt_hit;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            periph_q  <= 1'b0;
            soc_q     <= 1'b0;
            boot_q    <= 2'b00;
            test_q    <= 1'b0;
            cause_q   <= 2'd0;
            wdt_exp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            periph_q  <= periph_d;
            soc_q     <= soc_d;
            boot_q    <= boot_d;
            test_q    <= test_d;
            cause_q   <= cause_d;
            wdt_exp_q <= wdt_exp_d;
        end
    end

    assign periph_rst_no = periph_q;
    assign soc_rst_no    = soc_q;
    assign boot_mode_o   = boot_q;
    assign test_mode_o   = test_q;
    assign state_o       = state_q;
    assign rst_cause_o   = cause_q;
    assign wdt_expired_o = wdt_exp_q;

endmodule

// File: tb/tb_pb_rst_boot_seq.sv
// tb/tb_pb_rst_boot_seq.sv - self-checking bench for pb_rst_boot_seq (vector table, corner sequences, random vs model)
module tb_pb_rst_boot_seq;

    localparam int H = 16;
    localparam int P = 8;
    localparam int W = 4;
`ifdef PB_RST_BOOT_SEQ_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic       clk;
    logic       rst_ni;
    logic [1:0] boot_mode_i;
    logic       test_mode_i;
    logic       rtc_i;
    logic       sw_rst_req_i;
    logic       wdt_kick_i;
    logic       periph_rst_no;
    logic       soc_rst_no;
    logic [1:0] boot_mode_o;
    logic       test_mode_o;
    logic [1:0] state_o;
    logic [1:0] rst_cause_o;
    logic       wdt_expired_o;

    pb_rst_boot_seq #(
        .HoldCycles       (H),
        .PeriphToSocCycles(P),
        .WdtTicks         (W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .boot_mode_i  (boot_mode_i),
        .test_mode_i  (test_mode_i),
        .rtc_i        (rtc_i),
        .sw_rst_req_i (sw_rst_req_i),
        .wdt_kick_i   (wdt_kick_i),
        .periph_rst_no(periph_rst_no),
        .soc_rst_no   (soc_rst_no),
        .boot_mode_o  (boot_mode_o),
        .test_mode_o  (test_mode_o),
        .state_o      (state_o),
        .rst_cause_o  (rst_cause_o),
        .wdt_expired_o(wdt_expired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {periph_rst_no, soc_rst_no, state_o, boot_mode_o, test_mode_o, rst_cause_o, wdt_expired_o};
    endfunction

    // Reference model: the sequence is tracked as edges elapsed since entry.
    int         m_pos = 0;
    logic [1:0] m_boot = 0;
    logic       m_test = 0;
    logic [1:0] m_cause = 0;
    logic       m_exp = 0;
    int         m_wcnt = 0;
    logic [2:0] m_rtc_seen = 0;

    task automatic model_step();
        bit in_run, tick, hit;
        if (!rst_ni) begin
            m_pos = 0; m_boot = 0; m_test = 0; m_cause = 0; m_exp = 0;
            m_wcnt = 0; m_rtc_seen = 0;
        end else begin
            // a rise of rtc_i sampled two edges earlier is consumed as a tick now
            tick = WDT && m_rtc_seen[1] && !m_rtc_seen[2];
            m_rtc_seen = {m_rtc_seen[1:0], rtc_i};
            in_run = (m_pos >= H + 1 + P);
            hit = WDT && in_run && (m_wcnt == W);
            m_exp = hit;
            if (in_run && (sw_rst_req_i || hit)) begin
                m_pos = 0;
                m_cause = hit ? 2'd2 : 2'd1;
                m_wcnt = 0;
            end else begin
                if (m_pos == H) begin
                    m_boot = boot_mode_i;
                    m_test = test_mode_i;
                end
                if (!in_run) m_pos++;
                if (!in_run || wdt_kick_i) m_wcnt = 0;
                else if (tick) m_wcnt++;
            end
        end
    endtask

    function automatic logic [9:0] model_out();
        logic [1:0] st;
        if (m_pos < H) st = 2'd0;
        else if (m_pos == H) st = 2'd1;
        else if (m_pos < H + 1 + P) st = 2'd2;
        else st = 2'd3;
        return {(m_pos >= H + 1), (m_pos >= H + 1 + P), st, m_boot, m_test, m_cause, m_exp};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit         rst_n;
        logic [1:0] boot;
        bit         test;
        bit         sw;
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit   seen;
        int   rises;
        logic nr;
        int   rtc_left;

        //           rst boot test sw  n    periph soc state boot_o test_o cause exp
        tbl[0] = '{1'b0, 2'd2, 1'b0, 1'b0, 2,  {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0}};
        tbl[1] = '{1'b1, 2'd2, 1'b0, 1'b0, 16, {1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0}};
        tbl[2] = '{1'b1, 2'd2, 1'b0, 1'b0, 1,  {1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 2'd0, 1'b0}};
        tbl[3] = '{1'b1, 2'd2, 1'b0, 1'b0, 7,  {1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 2'd0, 1'b0}};
        tbl[4] = '{1'b1, 2'd2, 1'b0, 1'b0, 1,  {1'b1, 1'b1, 2'd3, 2'd2, 1'b0, 2'd0, 1'b0}};
        tbl[5] = '{1'b1, 2'd1, 1'b1, 1'b0, 5,  {1'b1, 1'b1, 2'd3, 2'd2, 1'b0, 2'd0, 1'b0}};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 1'b1, 1,  {1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd1, 1'b0}};
        tbl[7] = '{1'b1, 2'd1, 1'b1, 1'b0, 16, {1'b0, 1'b0, 2'd1, 2'd2, 1'b0, 2'd1, 1'b0}};
        tbl[8] = '{1'b1, 2'd1, 1'b1, 1'b0, 1,  {1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 2'd1, 1'b0}};
        tbl[9] = '{1'b1, 2'd1, 1'b1, 1'b0, 8,  {1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 2'd1, 1'b0}};

        rst_ni = 1'b0; boot_mode_i = 2'd2; test_mode_i = 1'b0;
        rtc_i = 1'b0; sw_rst_req_i = 1'b0; wdt_kick_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            rst_ni = tbl[i].rst_n; boot_mode_i = tbl[i].boot; test_mode_i = tbl[i].test;
            sw_rst_req_i = tbl[i].sw;
            cyc(1);
            sw_rst_req_i = 1'b0;
            if (tbl[i].n > 1) cyc(tbl[i].n - 1);
            chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // software request during PERIPH is dropped
        rst_ni = 1'b0; cyc(2); rst_ni = 1'b1;
        cyc(19);
        sw_rst_req_i = 1'b1; cyc(1); sw_rst_req_i = 1'b0;
        chk("sw_in_periph_state", {periph_rst_no, state_o}, {1'b1, 2'd2});
        cyc(4);
        chk("soc_low_edge24", soc_rst_no, 1'b0);
        cyc(1);
        chk("soc_high_edge25", soc_rst_no, 1'b1);
        cyc(40);
        chk("no_second_seq", {periph_rst_no, soc_rst_no, state_o, rst_cause_o}, {1'b1, 1'b1, 2'd3, 2'd0});

        // one-cycle rst_ni mid-sequence restarts from edge 1
        rst_ni = 1'b0; cyc(2); rst_ni = 1'b1;
        cyc(20);
        rst_ni = 1'b0; cyc(1); rst_ni = 1'b1;
        chk("mid_rst_outputs", dut_out(), 10'd0);
        cyc(24);
        chk("restart_edge24", {soc_rst_no, state_o}, {1'b0, 2'd2});
        cyc(1);
        chk("restart_edge25", {soc_rst_no, state_o}, {1'b1, 2'd3});

`ifdef PB_RST_BOOT_SEQ_WDT_EN
        seen = 0; rises = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            nr = ((k / 5) % 2) == 1;
            if (nr && !rtc_i) rises++;
            rtc_i = nr;
            cyc(1);
            if (wdt_expired_o) seen = 1;
        end
        chk("wdt_expiry_seen", seen, 1);
        chk("wdt_tick_count", rises, W);
        chk("wdt_cause_resets", {rst_cause_o, periph_rst_no, soc_rst_no}, {2'd2, 1'b0, 1'b0});
        cyc(1);
        chk("wdt_pulse_width", wdt_expired_o, 1'b0);
        rtc_i = 1'b0;
        cyc(30);
        seen = 0; rises = 0;
        for (int k = 0; k < 1000; k++) begin
            nr = ((k / 5) % 2) == 1;
            if (nr && !rtc_i) begin
                rises++;
                if (rises % 3 == 0) wdt_kick_i = 1'b1;
            end
            rtc_i = nr;
            cyc(1);
            wdt_kick_i = 1'b0;
            if (wdt_expired_o) seen = 1;
        end
        chk("wdt_kicked_no_expiry", {seen, state_o}, {1'b0, 2'd3});
`else
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            rtc_i = ((k / 5) % 2) == 1;
            cyc(1);
            if (wdt_expired_o) seen = 1;
        end
        chk("no_wdt_expiry", {seen, state_o, rst_cause_o}, {1'b0, 2'd3, 2'd0});
`endif

        // randomized stimulus against the model
        rst_ni = 1'b0; rtc_i = 1'b0; cyc(2);
        rtc_left = 4;
        for (int k = 0; k < 4000; k++) begin
            chk("random_vs_model", dut_out(), model_out());
            rst_ni       = ($urandom_range(0, 299) != 0);
            sw_rst_req_i = ($urandom_range(0, 19) == 0);
            wdt_kick_i   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) boot_mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) test_mode_i = ~test_mode_i;
            rtc_left--;
            if (rtc_left == 0) begin
                rtc_i = ~rtc_i;
                rtc_left = $urandom_range(3, 9);
            end
            cyc(1);
        end
        chk("random_final", dut_out(), model_out());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_rst_boot_seq.md
# pb_rst_boot_seq

Reset and boot-strap sequencer for the picobello top level. Holds the peripheral domain (UART, I2C, SPI host, serial link) and the Cheshire SoC domain in reset. Latches boot-mode and test-mode straps at a defined instant, then releases the two domains in order: peripherals first, SoC second. Handles software reset requests and, optionally, an RTC-clocked watchdog that re-runs the full sequence.

## Interface
Parameters:
- `HoldCycles`, 16, cycles both resets stay asserted after any reset entry; must be ≥1.
- `PeriphToSocCycles`, 8, cycles between `periph_rst_no` and `soc_rst_no` release; must be ≥1.
- `WdtTicks`, 1024, RTC rising edges without a kick before watchdog expiry; must be ≥2.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `boot_mode_i`  in  2  boot-mode straps, quasi-static.
- `test_mode_i`  in  1  test-mode strap, quasi-static.
- `rtc_i`  in  1  real-time clock, asynchronous to `clk_i`.
- `sw_rst_req_i`  in  1  single-cycle software reset request.
- `wdt_kick_i`  in  1  single-cycle watchdog kick.
- `periph_rst_no`  out  1  peripheral-domain reset, active-low, registered.
- `soc_rst_no`  out  1  SoC-domain reset, active-low, registered.
- `boot_mode_o`  out  2  latched boot mode.
- `test_mode_o`  out  1  latched test mode.
- `state_o`  out  2  FSM state: HOLD=0, SAMPLE=1, PERIPH=2, RUN=3.
- `rst_cause_o`  out  2  cause of last sequence: 0 = por, 1 = sw, 2 = wdt.
- `wdt_expired_o`  out  1  one-cycle expiry pulse.

## Operation
- `rst_ni` low:
  - state HOLD, counter 0.
  - `periph_rst_no`, `soc_rst_no`, `boot_mode_o`, `test_mode_o`, `wdt_expired_o` all 0.
  - `rst_cause_o` = 0. Watchdog counter and RTC sync flops cleared.
- **HOLD:** both resets low. Counter increments each cycle. When counter = `HoldCycles`−1, go to SAMPLE and clear the counter.
- **SAMPLE:** one cycle. Register `boot_mode_i` and `test_mode_i` into the outputs. Go to PERIPH and drive `periph_rst_no` = 1.
- **PERIPH:** `periph_rst_no` = 1, `soc_rst_no` = 0. Counter increments. When counter = `PeriphToSocCycles`−1, go to RUN and drive `soc_rst_no` = 1.
- **RUN:** both resets high. A reset request (sw or wdt) causes the next edge to:
  - enter HOLD,
  - drive both resets low,
  - clear the counter,
  - update `rst_cause_o`.
- `sw_rst_req_i` in HOLD, SAMPLE or PERIPH is dropped, not queued.
- sw request and wdt expiry in the same cycle: cause = 2 (wdt wins).
- `boot_mode_o` and `test_mode_o` hold their values outside SAMPLE and are re-latched on every sequence.
- RTC path:
  - 2-flop synchronizer, then an edge-detect flop.
  - tick = sync & ~prev.
  - One tick per `rtc_i` rising edge.

## Timing
- First edge with `rst_ni` high = edge 1.
- `periph_rst_no` rises after edge `HoldCycles`+1 (defaults: edge 17).
- `soc_rst_no` rises after edge `HoldCycles`+1+`PeriphToSocCycles` (defaults: edge 25).
- Straps are sampled at edge `HoldCycles`+1.
- Reset request in RUN: both resets low one edge after the request cycle.
- Full sequence from request to `soc_rst_no` high: 1+`HoldCycles`+1+`PeriphToSocCycles` edges.
- RTC tick is visible 3 `clk_i` cycles after the `rtc_i` rise; `rtc_i` high and low phases must each be ≥3 `clk_i` periods.
- Synchronous `rst_ni` assertion mid-sequence: outputs take reset values at the next edge, regardless of state.

## Configuration
- Macro `PB_RST_BOOT_SEQ_WDT_EN`.
- Defined:
  - Watchdog counter of width $clog2(`WdtTicks`+1) counts RTC ticks, in RUN only.
  - Counter is cleared in every other state and on `wdt_kick_i`.
  - Kick and tick in the same cycle: clear wins.
  - When counter reaches `WdtTicks`: `wdt_expired_o` pulses 1 cycle and the same edge's reset request carries cause 2. The counter is cleared as HOLD is entered.
- Undefined:
  - No counter and no RTC synchronizer.
  - `wdt_expired_o` tied 0, `wdt_kick_i` and `rtc_i` ignored.
  - `rst_cause_o` never 2.

## Test plan
- Power-on, defaults, `boot_mode_i`=2'b10, `test_mode_i`=0 → `periph_rst_no` high after edge 17, `soc_rst_no` high after edge 25, `boot_mode_o`=2'b10, `rst_cause_o`=0, `state_o` 0→1→2→3.
- Change `boot_mode_i` to 2'b01 while in RUN → `boot_mode_o` stays 2'b10. Then pulse `sw_rst_req_i` → both resets low next edge, `rst_cause_o`=1, `boot_mode_o`=2'b01 after re-sample, `soc_rst_no` high 25 edges after entering HOLD.
- `sw_rst_req_i` pulsed at edge 20 (PERIPH) → ignored; `soc_rst_no` still rises after edge 25; no second sequence.
- `rst_ni` asserted for 1 cycle at edge 21 → both resets 0, `boot_mode_o` 0, state HOLD; sequence restarts from edge 1.
- WDT_EN, `WdtTicks`=4, `rtc_i` period 10 clk, no kicks → `wdt_expired_o` pulses on the 4th RTC tick in RUN, `rst_cause_o`=2, resets drop. Repeat with a kick every 3 ticks → no expiry over 100 ticks.
- WDT_EN, expiry coincident with `sw_rst_req_i` → single sequence, `rst_cause_o`=2. Without WDT_EN, same stimulus → `wdt_expired_o` always 0.
